// File: rtl/mem_stage_lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
package mem_stage_lsu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_e;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef struct packed {
    logic [XLEN-1:0] loadData;
    logic            memExc;
    logic            busErr;
  } MEMStageLSUType;

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      LS_B:    store_be = 4'b0001 << off;
      LS_H:    store_be = 4'b0011 << {off[1], 1'b0};
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] store_data(input logic [2:0] f3, input logic [XLEN-1:0] d);
    case (f3)
      LS_B:    store_data = {4{d[7:0]}};
      LS_H:    store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

  // Reserved size codes, sized accesses with an unaligned address, or unsigned stores.
  function automatic logic access_bad(input logic [2:0] f3, input logic [1:0] off,
                                      input logic rd, input logic wr);
    logic illegal_f3;
    logic misaligned;
    illegal_f3 = (f3 == 3'b011) || (f3[2:1] == 2'b11);
    misaligned = ((f3[1:0] == 2'b01) && off[0]) || ((f3 == LS_W) && (off != 2'b00));
    access_bad = (rd && wr) || illegal_f3 || (wr && f3[2]) || misaligned;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Aligns a bus read word to the access offset and extends it to 32 bits.
module lsu_load_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [XLEN-1:0] dmRData,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] loadData
);

  logic [XLEN-1:0] sh;

  assign sh = dmRData >> {offset, 3'b000};

  always_comb begin
    loadData = sh;
    case (funct3)
      LS_B:    loadData = {{24{sh[7]}}, sh[7:0]};
      LS_H:    loadData = {{16{sh[15]}}, sh[15:0]};
      LS_BU:   loadData = {24'b0, sh[7:0]};
      LS_HU:   loadData = {16'b0, sh[15:0]};
      default: loadData = sh;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: single-beat data-bus master with alignment, faults and timeout.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            arst,
  input  logic            exValid,
  input  logic            memRead,
  input  logic            memWrite,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] storeData,
  input  logic            flush,
  output logic            dmReq,
  output logic            dmWe,
  output logic [XLEN-1:0] dmAddr,
  output logic [3:0]      dmBe,
  output logic [XLEN-1:0] dmWData,
  input  logic            dmGnt,
  input  logic            dmRValid,
  input  logic [XLEN-1:0] dmRData,
  output logic            lsuStall,
  output logic            lsuDone,
  output logic [XLEN-1:0] loadData,
  output logic            memExc,
  output logic            busErr,
  output logic [XLEN-1:0] excAddr
);

  lsu_state_e      state;
  logic [2:0]      fn_q;
  logic [1:0]      off_q;
  logic            kill_q;
  logic [CNT_W-1:0] cnt_q;
  MEMStageLSUType  res_q;

  logic             start_c;
  logic             bad_c;
  logic             tmo_c;
  logic [CNT_W-1:0] cnt_nxt;
  logic [XLEN-1:0]  fmt_c;

  assign start_c  = (state == IDLE) && exValid && (memRead || memWrite) && !flush;
  assign bad_c    = access_bad(funct3, addr[1:0], memRead, memWrite);
  assign cnt_nxt  = cnt_q + CNT_W'(1);
  assign tmo_c    = (BUS_TIMEOUT != 0) && (cnt_nxt >= CNT_W'(BUS_TIMEOUT));
  assign lsuStall = start_c || (state == REQ) || (state == WAIT);

  assign loadData = res_q.loadData;
  assign memExc   = res_q.memExc;
  assign busErr   = res_q.busErr;

  lsu_load_align u_align (
    .dmRData  (dmRData),
    .offset   (off_q),
    .funct3   (fn_q),
    .loadData (fmt_c)
  );

  // State, bus and result registers; a flushed op is tracked by kill_q and retires silently.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state   <= IDLE;
      fn_q    <= '0;
      off_q   <= '0;
      kill_q  <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      dmReq   <= 1'b0;
      dmWe    <= 1'b0;
      dmAddr  <= '0;
      dmBe    <= '0;
      dmWData <= '0;
      lsuDone <= 1'b0;
      excAddr <= '0;
    end else begin
      lsuDone <= 1'b0;
      case (state)
        IDLE: begin
          if (start_c) begin
            res_q.memExc <= bad_c;
            res_q.busErr <= 1'b0;
            fn_q    <= funct3;
            off_q   <= addr[1:0];
            kill_q  <= 1'b0;
            cnt_q   <= '0;
            dmWe    <= memWrite;
            dmAddr  <= {addr[31:2], 2'b00};
            dmBe    <= store_be(funct3, addr[1:0]);
            dmWData <= store_data(funct3, storeData);
            if (bad_c) begin
              excAddr <= addr;
              lsuDone <= 1'b1;
              state   <= DONE;
            end else begin
              dmReq <= 1'b1;
              state <= REQ;
            end
          end
        end
        REQ: begin
          if (dmGnt) begin
            dmReq <= 1'b0;
            cnt_q <= cnt_nxt;
            if (!dmWe) begin
              kill_q <= flush;
              state  <= WAIT;
            end else if (flush) begin
              state <= IDLE;
            end else begin
              lsuDone <= 1'b1;
              state   <= DONE;
            end
          end else if (flush) begin
            dmReq <= 1'b0;
            state <= IDLE;
          end else if (tmo_c) begin
            dmReq        <= 1'b0;
            res_q.busErr <= 1'b1;
            excAddr      <= {dmAddr[31:2], off_q};
            lsuDone      <= 1'b1;
            state        <= DONE;
          end else begin
            cnt_q <= cnt_nxt;
          end
        end
        WAIT: begin
          kill_q <= kill_q || flush;
          if (dmRValid) begin
            if (kill_q || flush) begin
              state <= IDLE;
            end else begin
              res_q.loadData <= fmt_c;
              lsuDone        <= 1'b1;
              state          <= DONE;
            end
          end else if (tmo_c) begin
            if (kill_q || flush) begin
              state <= IDLE;
            end else begin
              res_q.busErr <= 1'b1;
              excAddr      <= {dmAddr[31:2], off_q};
              lsuDone      <= 1'b1;
              state        <= DONE;
            end
          end else begin
            cnt_q <= cnt_nxt;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu (timeout parameter reduced to 4).
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        arst;
  logic        exValid, memRead, memWrite, flush;
  logic [2:0]  funct3;
  logic [31:0] addr, storeData;
  logic        dmReq, dmWe;
  logic [31:0] dmAddr, dmWData;
  logic [3:0]  dmBe;
  logic        dmGnt, dmRValid;
  logic [31:0] dmRData;
  logic        lsuStall, lsuDone, memExc, busErr;
  logic [31:0] loadData, excAddr;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.BUS_TIMEOUT(4)) dut (
    .clk(clk), .arst(arst), .exValid(exValid), .memRead(memRead), .memWrite(memWrite),
    .funct3(funct3), .addr(addr), .storeData(storeData), .flush(flush),
    .dmReq(dmReq), .dmWe(dmWe), .dmAddr(dmAddr), .dmBe(dmBe), .dmWData(dmWData),
    .dmGnt(dmGnt), .dmRValid(dmRValid), .dmRData(dmRData),
    .lsuStall(lsuStall), .lsuDone(lsuDone), .loadData(loadData),
    .memExc(memExc), .busErr(busErr), .excAddr(excAddr)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Load with grant in the first REQ cycle and data one cycle later; returns in the DONE cycle.
  task automatic run_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    exValid = 1'b1; memRead = 1'b1; memWrite = 1'b0; funct3 = f3; addr = a;
    cyc();
    exValid = 1'b0; memRead = 1'b0; dmGnt = 1'b1;
    cyc();
    dmGnt = 1'b0; dmRValid = 1'b1; dmRData = rd;
    cyc();
    dmRValid = 1'b0;
    #2;
  endtask

  task automatic start_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    exValid = 1'b1; memRead = 1'b0; memWrite = 1'b1; funct3 = f3; addr = a; storeData = d;
    cyc();
    exValid = 1'b0; memWrite = 1'b0;
    #2;
  endtask

  initial begin
    arst = 1'b1; exValid = 1'b0; memRead = 1'b0; memWrite = 1'b0; flush = 1'b0;
    funct3 = 3'b000; addr = '0; storeData = '0;
    dmGnt = 1'b0; dmRValid = 1'b0; dmRData = '0;
    cyc(); cyc();
    chk("rst_dmReq", dmReq, 0);
    chk("rst_stall", lsuStall, 0);
    chk("rst_loadData", loadData, 0);
    chk("rst_dmBe", dmBe, 0);
    chk("rst_excAddr", excAddr, 0);
    arst = 1'b0;

    // Valid but not a memory op: stays idle
    exValid = 1'b1;
    #2 chk("idle_stall", lsuStall, 0);
    cyc();
    chk("idle_dmReq", dmReq, 0);
    exValid = 1'b0;

    // LW 0x100, grant at cycle 2, data at cycle 4, done at cycle 5
    exValid = 1'b1; memRead = 1'b1; funct3 = 3'b010; addr = 32'h100;
    #2 chk("lw_c0_stall", lsuStall, 1);
    cyc();
    exValid = 1'b0; memRead = 1'b0;
    #2 chk("lw_c1_dmReq", dmReq, 1);
    chk("lw_c1_dmAddr", dmAddr, 32'h100);
    chk("lw_c1_dmWe", dmWe, 0);
    chk("lw_c1_stall", lsuStall, 1);
    cyc();
    dmGnt = 1'b1;
    #2 chk("lw_c2_dmReq", dmReq, 1);
    cyc();
    dmGnt = 1'b0;
    #2 chk("lw_c3_dmReq", dmReq, 0);
    chk("lw_c3_stall", lsuStall, 1);
    cyc();
    dmRValid = 1'b1; dmRData = 32'hDEADBEEF;
    #2 chk("lw_c4_stall", lsuStall, 1);
    chk("lw_c4_done", lsuDone, 0);
    cyc();
    dmRValid = 1'b0;
    #2 chk("lw_c5_done", lsuDone, 1);
    chk("lw_c5_stall", lsuStall, 0);
    chk("lw_c5_data", loadData, 32'hDEADBEEF);
    cyc();
    chk("lw_c6_done", lsuDone, 0);
    chk("lw_c6_hold", loadData, 32'hDEADBEEF);

    // Load formatting
    run_load(3'b000, 32'h103, 32'h80112233);
    chk("lb_done", lsuDone, 1);
    chk("lb_data", loadData, 32'hFFFFFF80);
    cyc();
    run_load(3'b100, 32'h103, 32'h80112233);
    chk("lbu_data", loadData, 32'h00000080);
    cyc();
    run_load(3'b001, 32'h102, 32'h80112233);
    chk("lh_data", loadData, 32'hFFFF8011);
    cyc();
    run_load(3'b101, 32'h100, 32'h1234F678);
    chk("lhu_data", loadData, 32'h0000F678);
    cyc();
    run_load(3'b000, 32'h101, 32'h80112233);
    chk("lb_off1_data", loadData, 32'h00000022);
    cyc();

    // Flush in WAIT: response consumed, no completion, loadData unchanged
    exValid = 1'b1; memRead = 1'b1; funct3 = 3'b010; addr = 32'h500;
    cyc();
    exValid = 1'b0; memRead = 1'b0; dmGnt = 1'b1;
    cyc();
    dmGnt = 1'b0; flush = 1'b1;
    #2 chk("fw_stall", lsuStall, 1);
    cyc();
    flush = 1'b0; dmRValid = 1'b1; dmRData = 32'h99999999;
    cyc();
    dmRValid = 1'b0;
    #2 chk("fw_done", lsuDone, 0);
    chk("fw_data", loadData, 32'h00000022);
    chk("fw_stall_idle", lsuStall, 0);

    // Stores: lanes, enables, no WAIT
    start_store(3'b001, 32'h202, 32'h0000ABCD);
    chk("sh_dmBe", dmBe, 4'b1100);
    chk("sh_wdata", dmWData, 32'hABCDABCD);
    chk("sh_dmAddr", dmAddr, 32'h200);
    chk("sh_dmWe", dmWe, 1);
    chk("sh_dmReq", dmReq, 1);
    dmGnt = 1'b1;
    cyc();
    dmGnt = 1'b0;
    #2 chk("sh_done", lsuDone, 1);
    chk("sh_stall", lsuStall, 0);
    chk("sh_dmReq_off", dmReq, 0);
    cyc();
    start_store(3'b000, 32'h201, 32'h000000A5);
    chk("sb_dmBe", dmBe, 4'b0010);
    chk("sb_wdata", dmWData, 32'hA5A5A5A5);
    dmGnt = 1'b1;
    cyc();
    dmGnt = 1'b0;
    cyc();
    start_store(3'b010, 32'h204, 32'h12345678);
    chk("sw_dmBe", dmBe, 4'b1111);
    chk("sw_wdata", dmWData, 32'h12345678);
    dmGnt = 1'b1;
    cyc();
    dmGnt = 1'b0;
    cyc();

    // Misaligned LW: exception, no bus request
    exValid = 1'b1; memRead = 1'b1; funct3 = 3'b010; addr = 32'h101;
    #2 chk("mis_stall", lsuStall, 1);
    cyc();
    exValid = 1'b0; memRead = 1'b0;
    #2 chk("mis_exc", memExc, 1);
    chk("mis_excAddr", excAddr, 32'h101);
    chk("mis_dmReq", dmReq, 0);
    chk("mis_done", lsuDone, 1);
    cyc();
    chk("mis_dmReq_idle", dmReq, 0);
    chk("mis_exc_hold", memExc, 1);

    // Read and write together is illegal
    exValid = 1'b1; memRead = 1'b1; memWrite = 1'b1; funct3 = 3'b010; addr = 32'h300;
    cyc();
    exValid = 1'b0; memRead = 1'b0; memWrite = 1'b0;
    #2 chk("rw_exc", memExc, 1);
    chk("rw_dmReq", dmReq, 0);
    cyc();
    // Unsigned-size store is illegal
    start_store(3'b100, 32'h310, 32'h1);
    chk("sbu_exc", memExc, 1);
    chk("sbu_excAddr", excAddr, 32'h310);
    cyc();

    // Flush in REQ before grant
    exValid = 1'b1; memRead = 1'b1; funct3 = 3'b010; addr = 32'h400;
    cyc();
    exValid = 1'b0; memRead = 1'b0; flush = 1'b1;
    #2 chk("fr_dmReq", dmReq, 1);
    chk("fr_exc_clr", memExc, 0);
    chk("fr_stall", lsuStall, 1);
    cyc();
    flush = 1'b0;
    #2 chk("fr_dmReq_off", dmReq, 0);
    chk("fr_done", lsuDone, 0);
    chk("fr_stall_idle", lsuStall, 0);
    cyc();

    // Timeout: four REQ cycles without grant
    exValid = 1'b1; memRead = 1'b1; funct3 = 3'b010; addr = 32'h300;
    cyc();
    exValid = 1'b0; memRead = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #2 chk($sformatf("to_req%0d", i), dmReq, 1);
      cyc();
    end
    #2 chk("to_busErr", busErr, 1);
    chk("to_dmReq", dmReq, 0);
    chk("to_excAddr", excAddr, 32'h300);
    chk("to_done", lsuDone, 1);
    cyc();

    // Reset in WAIT, late response ignored
    exValid = 1'b1; memRead = 1'b1; funct3 = 3'b010; addr = 32'h600;
    cyc();
    exValid = 1'b0; memRead = 1'b0; dmGnt = 1'b1;
    cyc();
    dmGnt = 1'b0; arst = 1'b1;
    #2 chk("rw_rst_stall", lsuStall, 0);
    chk("rw_rst_data", loadData, 0);
    cyc();
    arst = 1'b0; dmRValid = 1'b1; dmRData = 32'hCAFEF00D;
    cyc();
    dmRValid = 1'b0;
    #2 chk("rw_late_data", loadData, 0);
    chk("rw_late_done", lsuDone, 0);
    chk("rw_late_dmReq", dmReq, 0);
    chk("rw_late_busErr", busErr, 0);
    cyc();
    chk("rw_late_done2", lsuDone, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
